// File: rtl/sram_copy_dma_if.sv
// sram_copy_dma_if: both ports of a dual-port SRAM as seen by a copy engine.
//   master modport : copy engine side (drives addresses, write enables, data)
//   slave modport  : SRAM side (returns registered port A read data)
//   addr_a/we_a/data_a : port A (read side, we_a/data_a unused by the engine)
//   q_a                : port A registered read data
//   addr_b/we_b/data_b : port B (write side)
interface sram_copy_dma_if #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 8
);
    logic [DEPTH_LOG2-1:0] addr_a;
    logic                  we_a;
    logic [WIDTH-1:0]      data_a;
    logic [WIDTH-1:0]      q_a;
    logic [DEPTH_LOG2-1:0] addr_b;
    logic                  we_b;
    logic [WIDTH-1:0]      data_b;

    modport master (
        output addr_a, we_a, data_a, addr_b, we_b, data_b,
        input  q_a
    );

    modport slave (
        input  addr_a, we_a, data_a, addr_b, we_b, data_b,
        output q_a
    );
endinterface

// File: rtl/sram_copy_dma.sv
// sram_copy_dma: copies len words from a source region to a destination
// region of a dual-port SRAM. Port A streams reads, port B writes the
// returned word one cycle later, one word per cycle, 6-bit wrap-around
// addressing.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : command strobe, only looked at while idle
//   src_addr, dst_addr  : first source / destination word
//   len                 : word count, 0..DEPTH legal
//   busy                : copy in progress
//   done                : one-cycle completion pulse (also for len=0)
//   err                 : one-cycle pulse for a rejected command
//   mem                 : SRAM port signals (master side)
module sram_copy_dma #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] src_addr,
    input  logic [DEPTH_LOG2-1:0] dst_addr,
    input  logic [DEPTH_LOG2:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    sram_copy_dma_if.master       mem
);
    localparam int AW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, READ0, STREAM, DRAIN} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_a_q, addr_a_d;
    logic [AW-1:0]  addr_b_q, addr_b_d;
    logic [AW-1:0]  dst_q, dst_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           we_b_q, we_b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [AW-1:0]  diff;
    logic [LW-1:0]  cnt_nxt;
    logic           cmd_bad;

    // Distance from source to destination, modulo depth. A destination
    // 2..len-1 words ahead would overwrite source words before they are
    // read; distances 0 and 1 are safe because each read is sampled at or
    // before the edge that writes the same address.
    assign diff    = dst_addr - src_addr;
    assign cmd_bad = (len > LW'(DEPTH)) || ((diff >= AW'(2)) && ({1'b0, diff} < len));
    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        dst_d    = dst_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        we_b_d   = we_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_a_d = src_addr;
                        dst_d    = dst_addr;
                        len_d    = len;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = READ0;
                    end
                end
            end
            READ0, STREAM: begin
                // cnt_q is the index of the word whose read data arrives
                // at this edge; it is written on the following edge.
                addr_a_d = addr_a_q + 1'b1;
                addr_b_d = (state_q == READ0) ? dst_q : addr_b_q + 1'b1;
                we_b_d   = 1'b1;
                cnt_d    = cnt_nxt;
                state_d  = (cnt_nxt == len_q) ? DRAIN : STREAM;
            end
            DRAIN: begin
                we_b_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            we_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            we_b_q   <= we_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mem.addr_a = addr_a_q;
    assign mem.we_a   = 1'b0;
    assign mem.data_a = '0;
    assign mem.addr_b = addr_b_q;
    assign mem.we_b   = we_b_q;
    // Write data is the SRAM's registered read data, passed straight through.
    assign mem.data_b = mem.q_a;
endmodule

// File: tb/tb_sram_copy_dma.sv
// tb_sram_copy_dma: drives sram_copy_dma against a behavioural dual-port
// SRAM and checks memory contents, timing and handshakes against a
// reference memory image updated with plain copy arithmetic.
module tb_sram_copy_dma;
    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] src_addr, dst_addr;
    logic [6:0] len;
    logic       busy, done, err;

    int n_chk = 0;
    int n_err = 0;

    sram_copy_dma_if #(.DEPTH_LOG2(6), .WIDTH(8)) mem_if ();

    sram_copy_dma #(.DEPTH_LOG2(6), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model with a preload mux on port B.
    logic [7:0] ram [64];
    logic [7:0] ref_mem [64];
    logic       pl_en;
    logic [5:0] pl_addr;
    logic [7:0] pl_data;
    logic       wb_we;
    logic [5:0] wb_addr;
    logic [7:0] wb_data;

    assign wb_we   = pl_en ? 1'b1    : mem_if.we_b;
    assign wb_addr = pl_en ? pl_addr : mem_if.addr_b;
    assign wb_data = pl_en ? pl_data : mem_if.data_b;

    always @(posedge clk) begin
        mem_if.q_a <= ram[mem_if.addr_a];
        if (wb_we) ram[wb_addr] <= wb_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int nbad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] !== ref_mem[i]) nbad++;
        chk(tag, nbad, 0);
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 6'(i);
            pl_data = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one command and follow it to completion. With b2b=1 the task
    // returns in the done cycle so the next command is offered right there.
    task automatic run_cmd(input int s, input int d, input int n, input bit poke, input bit b2b);
        int dd, edge_done, busy_cyc, we_cyc, aa_bad, ab_bad;
        bit bad;
        logic [7:0] snap [64];
        dd  = (d - s + 64) % 64;
        bad = (n > 64) || (dd >= 2 && dd < n);
        if (!bad) begin
            for (int k = 0; k < n; k++) snap[k] = ref_mem[(s + k) % 64];
            for (int k = 0; k < n; k++) ref_mem[(d + k) % 64] = snap[k];
        end
        start = 1'b1; src_addr = 6'(s); dst_addr = 6'(d); len = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (bad) begin
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_done", done, 0);
        end else if (n == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
            chk("len0_we", mem_if.we_b, 0);
        end else begin
            chk("acc_busy", busy, 1);
            busy_cyc = 0; we_cyc = 0; aa_bad = 0; ab_bad = 0; edge_done = -1;
            for (int e = 1; e <= n + 8 && edge_done < 0; e++) begin
                if (busy) busy_cyc++;
                if (e - 1 < n && mem_if.addr_a !== 6'((s + e - 1) % 64)) aa_bad++;
                if (poke && n >= 4 && e == 3) begin
                    start = 1'b1; src_addr = 6'(s + 30); dst_addr = 6'(s + 30); len = 7'd3;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (mem_if.we_b) begin
                    if (mem_if.addr_b !== 6'((d + we_cyc) % 64)) ab_bad++;
                    we_cyc++;
                end
                if (done) edge_done = e;
            end
            chk("busy_cycles", busy_cyc, n + 1);
            chk("we_cycles", we_cyc, n);
            chk("done_edge", edge_done, n + 1);
            chk("addr_a_seq", aa_bad, 0);
            chk("addr_b_seq", ab_bad, 0);
            chk("end_busy", busy, 0);
        end
        chk_mem("mem");
        if (!b2b) begin
            @(posedge clk); #1;
            chk("pulse_done_low", done, 0);
            chk("pulse_err_low", err, 0);
        end
    endtask

    initial begin
        int done_seen;
        int s, d, n;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we_b", mem_if.we_b, 0);
        chk("rst_addr_a", mem_if.addr_a, 0);
        chk("rst_addr_b", mem_if.addr_b, 0);
        chk("we_a_zero", mem_if.we_a, 0);
        chk("data_a_zero", mem_if.data_a, 0);
        @(negedge clk);
        reset = 1'b0;
        preload();

        // Basic copy, wrap-around, edge lengths.
        run_cmd(4, 40, 8, 0, 0);
        chk("t1_first", ram[40], 8'hA1);
        chk("t1_last", ram[47], 8'hAE);
        run_cmd(60, 2, 6, 0, 0);
        run_cmd(5, 50, 0, 0, 0);
        run_cmd(9, 20, 1, 0, 0);
        chk("len1_val", ram[20], 8'hAC);
        run_cmd(0, 0, 64, 0, 0);

        // Overlap rules.
        run_cmd(10, 11, 5, 0, 0);
        run_cmd(10, 12, 5, 0, 0);
        run_cmd(3, 50, 65, 0, 0);
        run_cmd(62, 0, 4, 0, 0);

        // Start ignored while busy, then a start in the done cycle.
        run_cmd(20, 45, 10, 1, 1);
        run_cmd(1, 30, 4, 0, 0);

        // Reset in the middle of a copy.
        start = 1'b1; src_addr = 6'd0; dst_addr = 6'd32; len = 7'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we_b", mem_if.we_b, 0);
        chk("mid_rst_addr_a", mem_if.addr_a, 0);
        chk("mid_rst_addr_b", mem_if.addr_b, 0);
        chk("mid_rst_done", done, 0);
        ref_mem[32] = ref_mem[0];
        ref_mem[33] = ref_mem[1];
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);
        chk_mem("mid_rst_mem");
        run_cmd(0, 32, 10, 0, 0);

        // Random commands, biased toward short distances and edge lengths.
        for (int t = 0; t < 40; t++) begin
            s = int'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) d = (s + int'($urandom_range(0, 3))) % 64;
            else d = int'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) n = int'($urandom_range(0, 2));
            else n = int'($urandom_range(0, 66));
            run_cmd(s, d, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
